// File: rtl/code_sequencer.sv
// ---------------------------------------------------------------------------
// code_sequencer
//
// Transmit code sequencer for the HFSWR transmitter. Produces the per-chip
// binary phase code bit and the transmit-window strobe consumed by the
// downstream signal_code mapper. Each frame is one full code word sent at a
// programmable chip rate, followed by a silent guard interval; frames repeat
// back-to-back while enable is held high.
//
// Parameters:
//   CODE_LEN   chips per frame (1..32)
//   CODE_WORD  code bits, bit CODE_LEN-1 is sent first
//   CHIP_DIV   clock cycles per chip (>=1)
//   GUARD_CYC  silent cycles after each frame (>=1)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   enable       level; frames run while high
//   code         current chip value, 0 outside the transmit window
//   sinc         high during the transmit window
//   frame_start  one-cycle pulse on the first transmit cycle of each frame
//   busy         high while transmitting or in the guard interval
//   frame_cnt    frames started since reset, wraps at 16 bits
//
// Build option:
//   CODE_SEQ_LFSR_EN  when defined, chips come from a 7-bit Fibonacci LFSR
//                     (x^7+x^6+1, seed 7'h7F reloaded per frame, 127 chips)
//                     and CODE_LEN / CODE_WORD are ignored.
// ---------------------------------------------------------------------------
module code_sequencer #(
   parameter int          CODE_LEN  = 13,
   parameter logic [31:0] CODE_WORD = 32'h00001F35,
   parameter int          CHIP_DIV  = 100,
   parameter int          GUARD_CYC = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic        code,
   output logic        sinc,
   output logic        frame_start,
   output logic        busy,
   output logic [15:0] frame_cnt
);

`ifdef CODE_SEQ_LFSR_EN
   localparam int NUM_CHIPS = 127;
`else
   localparam int NUM_CHIPS = CODE_LEN;
`endif

   localparam int CYC_W = (CHIP_DIV  > 1) ? $clog2(CHIP_DIV)  : 1;
   localparam int IDX_W = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
   localparam int GRD_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CHIP_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHIPS - 1);
   localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(GUARD_CYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TX    = 2'd1,
      GUARD = 2'd2
   } state_t;

   state_t           state;
   logic [CYC_W-1:0] cyc_cnt;
   logic [IDX_W-1:0] chip_idx;
   logic [GRD_W-1:0] guard_cnt;

   logic chip_end;
   logic last_chip;
   logic guard_end;
   logic start_frame;
   logic first_chip;
   logic next_chip;

   assign chip_end  = (cyc_cnt == CYC_LAST);
   assign last_chip = (chip_idx == IDX_LAST);
   assign guard_end = (guard_cnt == GRD_LAST);

   // A frame starts either from IDLE or straight out of the last guard cycle,
   // so back-to-back frames have no idle gap between them.
   assign start_frame = enable &&
                        ((state == IDLE) || ((state == GUARD) && guard_end));

`ifdef CODE_SEQ_LFSR_EN
   logic [6:0] lfsr;
   logic [6:0] lfsr_next;

   // Fibonacci shift with feedback from taps 7 and 6 entering at bit 0.
   assign lfsr_next  = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
   assign first_chip = 1'b1;
   assign next_chip  = lfsr_next[0];
`else
   logic [(1<<IDX_W)-1:0] chip_rom;
   logic [IDX_W-1:0]      next_idx;

   // Reorder the code word so that chip k sits at index k; the unused top
   // entries (non power-of-two lengths) are tied off and never selected.
   for (genvar k = 0; k < (1 << IDX_W); k++) begin : g_rom
      if (k < CODE_LEN) begin : g_used
         assign chip_rom[k] = CODE_WORD[CODE_LEN-1-k];
      end else begin : g_pad
         assign chip_rom[k] = 1'b0;
      end
   end

   assign next_idx   = chip_idx + 1'b1;
   assign first_chip = chip_rom[0];
   assign next_chip  = chip_rom[next_idx];
`endif

   // Single state machine with registered outputs: the output registers are
   // loaded with the value belonging to the state being entered, so the
   // outputs line up with the state without any extra pipeline cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cyc_cnt     <= '0;
         chip_idx    <= '0;
         guard_cnt   <= '0;
         code        <= 1'b0;
         sinc        <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
         frame_cnt   <= 16'd0;
`ifdef CODE_SEQ_LFSR_EN
         lfsr        <= '0;
`endif
      end else begin
         frame_start <= 1'b0;
         if (start_frame) begin
            state       <= TX;
            cyc_cnt     <= '0;
            chip_idx    <= '0;
            guard_cnt   <= '0;
            code        <= first_chip;
            sinc        <= 1'b1;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
`ifdef CODE_SEQ_LFSR_EN
            lfsr        <= 7'h7F;
`endif
         end else begin
            case (state)
               TX: begin
                  if (chip_end) begin
                     cyc_cnt <= '0;
                     if (last_chip) begin
                        state     <= GUARD;
                        guard_cnt <= '0;
                        sinc      <= 1'b0;
                        code      <= 1'b0;
                     end else begin
                        chip_idx <= chip_idx + 1'b1;
                        code     <= next_chip;
`ifdef CODE_SEQ_LFSR_EN
                        lfsr     <= lfsr_next;
`endif
                     end
                  end else begin
                     cyc_cnt <= cyc_cnt + 1'b1;
                  end
               end
               GUARD: begin
                  // enable low on the last guard cycle returns to IDLE;
                  // enable high is handled by start_frame above.
                  if (guard_end) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     guard_cnt <= guard_cnt + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
                  sinc  <= 1'b0;
                  code  <= 1'b0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_code_sequencer.sv
// ---------------------------------------------------------------------------
// tb_code_sequencer
//
// Self-checking bench for code_sequencer with CHIP_DIV=2, GUARD_CYC=4,
// CODE_LEN=13, CODE_WORD=0x1F35. A frame-position reference model runs in
// lock-step with the DUT for every cycle; a table of fixed expectations covers
// the single-frame case, and hand-written sequences cover back-to-back frames,
// mid-frame enable drop, asynchronous reset mid-transmit and counter wrap.
// ---------------------------------------------------------------------------
module tb_code_sequencer;

   localparam int          CODE_LEN  = 13;
   localparam logic [31:0] CODE_WORD = 32'h00001F35;
   localparam int          CHIP_DIV  = 2;
   localparam int          GUARD_CYC = 4;
   localparam int          TX_CYC    = CODE_LEN * CHIP_DIV;
   localparam int          PERIOD    = TX_CYC + GUARD_CYC;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        code;
   logic        sinc;
   logic        frame_start;
   logic        busy;
   logic [15:0] frame_cnt;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int sinc_hi = 0;
   int fs_hi = 0;
   int busy_hi = 0;

   // Reference model: whether a frame is in progress and the cycle position
   // inside it (0..PERIOD-1), plus the number of frames started.
   bit          m_active = 1'b0;
   int          m_pos = 0;
   logic [15:0] m_fcnt = 16'd0;

   typedef struct {
      int          offset;
      logic        sinc;
      logic        code;
      logic        fs;
      logic        busy;
      logic [15:0] fcnt;
   } vec_t;

   vec_t vecs[15];

   code_sequencer #(
      .CODE_LEN  (CODE_LEN),
      .CODE_WORD (CODE_WORD),
      .CHIP_DIV  (CHIP_DIV),
      .GUARD_CYC (GUARD_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .code        (code),
      .sinc        (sinc),
      .frame_start (frame_start),
      .busy        (busy),
      .frame_cnt   (frame_cnt)
   );

   always #5 clk = ~clk;

   // Hard time limit so the run always ends even if the design wedges.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic chip_of(input int k);
      logic [31:0] t;
      t = CODE_WORD >> (CODE_LEN - 1 - k);
      return t[0];
   endfunction

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s at cycle %0d: got %b required %b", name, cyc, act, exp);
      end
   endtask

   task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s at cycle %0d: got %h required %h", name, cyc, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic model_edge(input logic en);
      if (!m_active) begin
         if (en) begin
            m_active = 1'b1;
            m_pos    = 0;
            m_fcnt   = m_fcnt + 16'd1;
         end
      end else if (m_pos == PERIOD - 1) begin
         if (en) begin
            m_pos  = 0;
            m_fcnt = m_fcnt + 16'd1;
         end else begin
            m_active = 1'b0;
         end
      end else begin
         m_pos++;
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_pos    = 0;
      m_fcnt   = 16'd0;
   endtask

   task automatic check_output();
      logic e_sinc;
      logic e_code;
      e_sinc = m_active && (m_pos < TX_CYC);
      e_code = e_sinc ? chip_of(m_pos / CHIP_DIV) : 1'b0;
      check_bit("model_sinc", sinc, e_sinc);
      check_bit("model_code", code, e_code);
      check_bit("model_frame_start", frame_start, m_active && (m_pos == 0));
      check_bit("model_busy", busy, m_active);
      check_word("model_frame_cnt", frame_cnt, m_fcnt);
   endtask

   // One clock: the model sees the enable value sampled at the edge, outputs
   // are compared 1 time unit later.
   task automatic step();
      logic en_s;
      @(posedge clk);
      en_s = enable;
      model_edge(en_s);
      #1;
      cyc++;
      if (sinc) sinc_hi++;
      if (frame_start) fs_hi++;
      if (busy) busy_hi++;
      check_output();
   endtask

   task automatic check_all_zero(input string tag);
      check_bit({tag, "_sinc"}, sinc, 1'b0);
      check_bit({tag, "_code"}, code, 1'b0);
      check_bit({tag, "_frame_start"}, frame_start, 1'b0);
      check_bit({tag, "_busy"}, busy, 1'b0);
      check_word({tag, "_frame_cnt"}, frame_cnt, 16'd0);
   endtask

   task automatic apply_stimulus_reset();
      rst    = 1'b0;
      enable = 1'b0;
      #3;
      model_reset();
      check_all_zero("reset");
      @(negedge clk);
      rst     = 1'b1;
      sinc_hi = 0;
      fs_hi   = 0;
      busy_hi = 0;
   endtask

   task automatic run_idle(input int n);
      enable = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int off;
      int nfs;
      int fs_at[3];
      int hold;

      vecs[0]  = '{0,  1'b1, 1'b1, 1'b1, 1'b1, 16'd1};
      vecs[1]  = '{1,  1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
      vecs[2]  = '{9,  1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
      vecs[3]  = '{10, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
      vecs[4]  = '{13, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
      vecs[5]  = '{14, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
      vecs[6]  = '{17, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
      vecs[7]  = '{18, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
      vecs[8]  = '{20, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
      vecs[9]  = '{23, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};
      vecs[10] = '{25, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1};
      vecs[11] = '{26, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
      vecs[12] = '{29, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
      vecs[13] = '{30, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};
      vecs[14] = '{33, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1};

      // Single frame from a one-cycle enable pulse, checked against the table.
      $display("[TB] single frame");
      apply_stimulus_reset();
      run_idle(2);
      sinc_hi = 0;
      fs_hi   = 0;
      enable  = 1'b1;
      step();
      enable  = 1'b0;
      off     = 0;
      foreach (vecs[i]) begin
         while (off < vecs[i].offset) begin
            step();
            off++;
         end
         check_bit("tbl_sinc", sinc, vecs[i].sinc);
         check_bit("tbl_code", code, vecs[i].code);
         check_bit("tbl_frame_start", frame_start, vecs[i].fs);
         check_bit("tbl_busy", busy, vecs[i].busy);
         check_word("tbl_frame_cnt", frame_cnt, vecs[i].fcnt);
      end
      check_int("single_sinc_cycles", sinc_hi, 26);
      check_int("single_frame_starts", fs_hi, 1);

      // Continuous frames: three starts spaced by the full frame period.
      $display("[TB] continuous frames");
      apply_stimulus_reset();
      nfs    = 0;
      fs_at  = '{0, 0, 0};
      enable = 1'b1;
      for (int i = 0; i < 200 && nfs < 3; i++) begin
         step();
         if (frame_start) begin
            fs_at[nfs] = cyc;
            nfs++;
         end
      end
      enable = 1'b0;
      check_int("cont_starts_seen", nfs, 3);
      check_int("cont_period_1", fs_at[1] - fs_at[0], 30);
      check_int("cont_period_2", fs_at[2] - fs_at[0], 60);
      run_idle(40);
      check_word("cont_frame_cnt", frame_cnt, 16'd3);

      // Enable dropped at chip 5: the whole frame and its guard still run.
      $display("[TB] mid-frame enable drop");
      apply_stimulus_reset();
      enable = 1'b1;
      step();
      for (int i = 1; i < 10; i++) step();
      enable = 1'b0;
      for (int i = 0; i < 100 && busy; i++) step();
      check_bit("drop_idle_busy", busy, 1'b0);
      check_int("drop_sinc_cycles", sinc_hi, 26);
      check_int("drop_busy_cycles", busy_hi, 30);
      run_idle(5);

      // Asynchronous reset at chip 7, between clock edges.
      $display("[TB] async reset mid-frame");
      apply_stimulus_reset();
      enable = 1'b1;
      step();
      enable = 1'b0;
      for (int i = 1; i <= 14; i++) step();
      check_bit("pre_reset_sinc", sinc, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_all_zero("async_reset");
      enable = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      step();
      enable = 1'b0;
      check_bit("restart_frame_start", frame_start, 1'b1);
      check_bit("restart_code_chip0", code, 1'b1);
      check_word("restart_frame_cnt", frame_cnt, 16'd1);
      run_idle(40);

      // Counter wrap: preload 0xFFFF while idle, then start one frame.
      $display("[TB] frame counter wrap");
      force dut.frame_cnt = 16'hFFFF;
      #1;
      release dut.frame_cnt;
      #1;
      m_fcnt = 16'hFFFF;
      check_word("wrap_preload", frame_cnt, 16'hFFFF);
      enable = 1'b1;
      step();
      enable = 1'b0;
      check_word("wrap_frame_cnt", frame_cnt, 16'h0000);
      check_bit("wrap_frame_start", frame_start, 1'b1);
      run_idle(40);

      // Random enable patterns with the occasional asynchronous reset.
      $display("[TB] random stimulus");
      apply_stimulus_reset();
      hold = 0;
      for (int i = 0; i < 1500; i++) begin
         if (hold == 0) begin
            enable = ($urandom_range(0, 3) != 0);
            hold   = $urandom_range(1, 40);
         end
         hold--;
         step();
         if ($urandom_range(0, 299) == 0) begin
            #2;
            rst = 1'b0;
            #1;
            model_reset();
            check_all_zero("rand_reset");
            @(negedge clk);
            rst = 1'b1;
         end
      end
      run_idle(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
